// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10,
    KILL = 2'b11
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue with a registered head; flush wins over push and pop.
module fetch_fifo #(
  parameter int unsigned      WIDTH = 64,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-1:0] EMPTY = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic                    head_valid,
  output logic [WIDTH-1:0]        head_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [CW-1:0]    count_nx;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    count_nx  = count;
    if (flush) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
      count_nx  = '0;
    end else begin
      if (push_ok) wr_ptr_nx = wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr_nx = rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count_nx = count + CW'(1);
      else if (pop_ok && !push_ok) count_nx = count - CW'(1);
    end
  end

  // Head register looks ahead to the next read pointer, bypassing a write into that slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= EMPTY;
    end else begin
      wr_ptr     <= wr_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      count      <= count_nx;
      head_valid <= (count_nx != '0);
      if (count_nx == '0)
        head_data <= EMPTY;
      else if (push_ok && !flush && (wr_ptr == rd_ptr_nx))
        head_data <= push_data;
      else
        head_data <= mem[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Sequential instruction fetch into a prefetch queue, one outstanding icache
// request at a time, with redirect flush and kill of in-flight responses.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = XLEN'(NOP_INSN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ic_req,
  output logic [XLEN-1:0] ic_addr,
  input  logic            ic_gnt,
  input  logic            ic_valid,
  input  logic [XLEN-1:0] ic_data,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [XLEN-1:0] ir_code,
  output logic [XLEN-1:0] ir_pc,
  output logic            busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_nx;
  logic [XLEN-1:0]   fetch_pc, fetch_pc_nx, req_pc;
  logic [CW-1:0]     count, count_nx;
  logic              gnt, push, pop, head_valid;
  logic [2*XLEN-1:0] head_data;

  assign gnt  = ic_req && ic_gnt;
  assign push = (state == WAIT) && ic_valid && !redirect;
  assign pop  = head_valid && ir_ready && !redirect;

  assign ic_addr  = fetch_pc;
  assign ir_valid = head_valid;
  assign ir_pc    = head_data[2*XLEN-1:XLEN];
  assign ir_code  = head_data[XLEN-1:0];

  // Next state, next fetch address and next occupancy.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    count_nx    = count;
    if (redirect) begin
      fetch_pc_nx = {redirect_pc[XLEN-1:2], 2'b00};
      count_nx    = '0;
      // Stay in KILL only while a response is still owed by the icache.
      if ((((state == WAIT) || (state == KILL)) && !ic_valid) || ((state == RUN) && gnt))
        state_nx = KILL;
      else
        state_nx = RUN;
    end else begin
      if (push && !pop)      count_nx = count + CW'(1);
      else if (pop && !push) count_nx = count - CW'(1);
      case (state)
        IDLE: state_nx = RUN;
        RUN: begin
          if (gnt) begin
            state_nx    = WAIT;
            fetch_pc_nx = fetch_pc + XLEN'(PC_INC);
          end
        end
        WAIT:    if (ic_valid) state_nx = RUN;
        KILL:    if (ic_valid) state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // ic_req is registered from next state/occupancy so a slot is reserved before issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      ic_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      if (gnt) req_pc <= fetch_pc;
      ic_req   <= (state_nx == RUN) && (count_nx < CW'(DEPTH));
      busy     <= (state_nx == WAIT) || (state_nx == KILL);
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH),
    .EMPTY ({{XLEN{1'b0}}, NOP})
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_data  ({req_pc, ic_data}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (count)
  );

endmodule
